route_compute_unit: RTL
=======================

ROUTE_COMPUTE_UNIT -- requirements
Module: route_compute_unit

Interface
REQ-001 The module SHALL have parameter X_ADDR_W, default 8, meaning x-address field width.
REQ-002 The module SHALL have parameter Y_ADDR_W, default 8, meaning y-address field width.
REQ-003 The module SHALL have parameter X_COORDINATE, default 0, meaning this router's x position.
REQ-004 The module SHALL have parameter Y_COORDINATE, default 0, meaning this router's y position.
REQ-005 The module SHALL have parameter FLIT_W, default 32, meaning flit width, which SHALL be at least X_ADDR_W+Y_ADDR_W+2.
REQ-006 The module SHALL have parameter ROUTE_MODE, default 0, meaning dimension order: 0 = XY, 1 = YX.
REQ-007 The module SHALL have port clk, input, width 1: the single clock; all state changes on the rising edge.
REQ-008 The module SHALL have port rst, input, width 1: the reset, asynchronous and active-high.
REQ-009 The module SHALL have port in_flit, input, width FLIT_W: the incoming flit.
REQ-010 The module SHALL have port in_valid, input, width 1: in_flit is valid.
REQ-011 The module SHALL have port in_ready, output, width 1: the unit can accept a flit this cycle.
REQ-012 The module SHALL have port out_flit, output, width FLIT_W: the registered flit.
REQ-013 The module SHALL have port out_valid, output, width 1: out_flit is valid.
REQ-014 The module SHALL have port out_ready, input, width 1: downstream accepts out_flit.
REQ-015 The module SHALL have port request_vector, output, width 5, bits high to low west/east/south/north/local: one-hot arbiter request.
REQ-016 The module SHALL have port destination_port, output, width 3: the encoded port (0 none, 1 local, 2 north, 3 south, 4 east, 5 west).
REQ-017 The module SHALL have port err_count, output, width 8: saturating count of framing errors.

Function
REQ-018 The flit type SHALL be in_flit[FLIT_W-1:FLIT_W-2], encoded 01 head, 00 body, 10 tail, 11 single (head and tail).
REQ-019 In head and single flits, x SHALL be in_flit[X_ADDR_W-1:0] and y SHALL be in_flit[X_ADDR_W+Y_ADDR_W-1:X_ADDR_W]; both are compared unsigned.
REQ-020 In XY mode, the route SHALL be east if x > X, west if x < X, otherwise north if y > Y, south if y < Y, otherwise local.
REQ-021 In YX mode, the route SHALL be north if y > Y, south if y < Y, otherwise east if x > X, west if x < X, otherwise local.
REQ-022 The unit SHALL have one output register, with in_ready = !out_valid || out_ready; a flit transfers when in_valid && in_ready.
REQ-023 Latency SHALL be exactly one cycle from input transfer to out_valid with the same flit.
REQ-024 The unit SHALL implement a two-state FSM: IDLE (no packet open) and PKT (packet open).
REQ-025 In IDLE, an accepted head SHALL latch the route and move the FSM to PKT.
REQ-026 In IDLE, an accepted single SHALL latch the route and keep the FSM in IDLE.
REQ-027 In PKT, an accepted body SHALL be forwarded under the latched route.
REQ-028 In PKT, an accepted tail SHALL be forwarded under the latched route and move the FSM to IDLE.
REQ-029 A body or tail accepted in IDLE SHALL be dropped (out_valid not set) and SHALL increment err_count.
REQ-030 A head or single accepted in PKT SHALL be forwarded under the current route without re-routing and SHALL increment err_count; the FSM stays in PKT.
REQ-031 err_count SHALL saturate at 255.
REQ-032 request_vector and destination_port SHALL reflect the latched route only while out_valid is 1, and SHALL be 0 otherwise.
REQ-033 out_flit SHALL hold stable while out_valid && !out_ready.
REQ-034 When the output flit transfers in the same cycle as a new input transfer, the register SHALL load the new flit with no bubble.

Reset
REQ-035 While rst is high, out_valid, out_flit, request_vector, destination_port and err_count SHALL be 0 and the FSM SHALL be in IDLE.
REQ-036 An assertion of rst mid-packet SHALL discard the open packet and any held flit, with no error counted.

Structure
REQ-037 The port encodings, one-hot request constants and flit-type codes SHALL reside in shared package noc_pkg.
REQ-038 The combinational route decision SHALL be one sub-module, route_decode, parameterised by widths, coordinates and ROUTE_MODE.

Verification
REQ-039 XY mode, X=Y=2, single flit with x=5, y=0 -> one cycle later out_valid=1, request_vector=01000, destination_port=4.
REQ-040 YX mode, same flit -> request_vector=00100, destination_port=3.
REQ-041 XY mode, head with x=2, y=2, then 2 bodies and a tail, out_ready held 0 for 3 cycles mid-packet -> all 4 flits delivered in order with request_vector=00001, and out_flit stable while stalled.
REQ-042 Tail flit while IDLE -> no output, err_count=1; then 300 such flits -> err_count=255.
REQ-043 Head, then a second head before the tail -> second head exits with the first route, err_count increments by 1, and the FSM returns to IDLE only after the tail.
REQ-044 rst asserted after the head and one body -> all outputs 0 immediately; a following body is dropped and counted as err_count=1.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: output-port codes, one-hot arbiter requests, flit types.
package noc_pkg;

   localparam int unsigned PORT_W = 3;
   localparam int unsigned REQ_W  = 5;

   // Encoded output ports
   localparam logic [PORT_W-1:0] PORT_NONE  = 3'd0;
   localparam logic [PORT_W-1:0] PORT_LOCAL = 3'd1;
   localparam logic [PORT_W-1:0] PORT_NORTH = 3'd2;
   localparam logic [PORT_W-1:0] PORT_SOUTH = 3'd3;
   localparam logic [PORT_W-1:0] PORT_EAST  = 3'd4;
   localparam logic [PORT_W-1:0] PORT_WEST  = 3'd5;

   // One-hot requests, bits high to low west/east/south/north/local
   localparam logic [REQ_W-1:0] REQ_NONE  = 5'b00000;
   localparam logic [REQ_W-1:0] REQ_LOCAL = 5'b00001;
   localparam logic [REQ_W-1:0] REQ_NORTH = 5'b00010;
   localparam logic [REQ_W-1:0] REQ_SOUTH = 5'b00100;
   localparam logic [REQ_W-1:0] REQ_EAST  = 5'b01000;
   localparam logic [REQ_W-1:0] REQ_WEST  = 5'b10000;

   typedef enum logic [1:0] {
      FT_BODY   = 2'b00,
      FT_HEAD   = 2'b01,
      FT_TAIL   = 2'b10,
      FT_SINGLE = 2'b11
   } flit_type_e;

   // Map an encoded port to its one-hot arbiter request
   function automatic logic [REQ_W-1:0] port_onehot(input logic [PORT_W-1:0] p);
      logic [REQ_W-1:0] r;
      r = REQ_NONE;
      case (p)
         PORT_LOCAL: r = REQ_LOCAL;
         PORT_NORTH: r = REQ_NORTH;
         PORT_SOUTH: r = REQ_SOUTH;
         PORT_EAST:  r = REQ_EAST;
         PORT_WEST:  r = REQ_WEST;
         default:    r = REQ_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/route_decode.sv
// Combinational dimension-order route decision.
// Ports: x_addr_i/y_addr_i destination coordinates; port_c encoded output port.
module route_decode
   import noc_pkg::*;
#(
   parameter int unsigned X_ADDR_W     = 8,
   parameter int unsigned Y_ADDR_W     = 8,
   parameter int unsigned X_COORDINATE = 0,
   parameter int unsigned Y_COORDINATE = 0,
   parameter int unsigned ROUTE_MODE   = 0
) (
   input  logic [X_ADDR_W-1:0] x_addr_i,
   input  logic [Y_ADDR_W-1:0] y_addr_i,
   output logic [PORT_W-1:0]   port_c
);

   localparam logic [X_ADDR_W-1:0] MY_X = X_ADDR_W'(X_COORDINATE);
   localparam logic [Y_ADDR_W-1:0] MY_Y = Y_ADDR_W'(Y_COORDINATE);

   logic [PORT_W-1:0] x_port_c;
   logic [PORT_W-1:0] y_port_c;

   // Per-dimension decision; PORT_NONE means that dimension is resolved
   always_comb begin
      x_port_c = PORT_NONE;
      y_port_c = PORT_NONE;
      if (x_addr_i > MY_X)      x_port_c = PORT_EAST;
      else if (x_addr_i < MY_X) x_port_c = PORT_WEST;
      if (y_addr_i > MY_Y)      y_port_c = PORT_NORTH;
      else if (y_addr_i < MY_Y) y_port_c = PORT_SOUTH;
   end

   // Resolve the first dimension, then the second, then deliver locally
   always_comb begin
      port_c = PORT_LOCAL;
      if (ROUTE_MODE == 0) begin
         if (x_port_c != PORT_NONE)      port_c = x_port_c;
         else if (y_port_c != PORT_NONE) port_c = y_port_c;
      end else begin
         if (y_port_c != PORT_NONE)      port_c = y_port_c;
         else if (x_port_c != PORT_NONE) port_c = x_port_c;
      end
   end

endmodule

// File: rtl/route_compute_unit.sv
// Route-compute stage: routes head/single flits, carries the route through
// the packet, registers one flit with a ready/valid handshake, counts
// framing errors.
// Ports: clk/rst; in_flit/in_valid/in_ready upstream; out_flit/out_valid/
// out_ready downstream; request_vector/destination_port route of the held
// flit; err_count saturating framing-error count.
module route_compute_unit
   import noc_pkg::*;
#(
   parameter int unsigned X_ADDR_W     = 8,
   parameter int unsigned Y_ADDR_W     = 8,
   parameter int unsigned X_COORDINATE = 0,
   parameter int unsigned Y_COORDINATE = 0,
   parameter int unsigned FLIT_W       = 32,
   parameter int unsigned ROUTE_MODE   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLIT_W-1:0] in_flit,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [FLIT_W-1:0] out_flit,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        request_vector,
   output logic [2:0]        destination_port,
   output logic [7:0]        err_count
);

   typedef enum logic {S_IDLE = 1'b0, S_PKT = 1'b1} state_e;

   state_e            state_q;
   logic [PORT_W-1:0] route_q;
   logic [FLIT_W-1:0] out_flit_q;
   logic              out_valid_q;
   logic [PORT_W-1:0] dest_q;
   logic [REQ_W-1:0]  req_q;
   logic [7:0]        err_q;

   logic              accept_c;
   flit_type_e        ftype_c;
   logic [PORT_W-1:0] new_port_c;

   route_decode #(
      .X_ADDR_W     (X_ADDR_W),
      .Y_ADDR_W     (Y_ADDR_W),
      .X_COORDINATE (X_COORDINATE),
      .Y_COORDINATE (Y_COORDINATE),
      .ROUTE_MODE   (ROUTE_MODE)
   ) u_route_decode (
      .x_addr_i (in_flit[X_ADDR_W-1:0]),
      .y_addr_i (in_flit[X_ADDR_W+Y_ADDR_W-1:X_ADDR_W]),
      .port_c   (new_port_c)
   );

   assign in_ready = !out_valid_q || out_ready;
   assign accept_c = in_valid && in_ready;
   assign ftype_c  = flit_type_e'(in_flit[FLIT_W-1:FLIT_W-2]);

   // Packet FSM, output register and error counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         route_q     <= PORT_NONE;
         out_flit_q  <= '0;
         out_valid_q <= 1'b0;
         dest_q      <= PORT_NONE;
         req_q       <= REQ_NONE;
         err_q       <= 8'd0;
      end else begin
         // Held flit leaves; overridden below if a new flit loads
         if (out_ready) begin
            out_valid_q <= 1'b0;
            dest_q      <= PORT_NONE;
            req_q       <= REQ_NONE;
         end
         if (accept_c) begin
            if (state_q == S_IDLE) begin
               if (ftype_c == FT_HEAD || ftype_c == FT_SINGLE) begin
                  route_q     <= new_port_c;
                  out_flit_q  <= in_flit;
                  out_valid_q <= 1'b1;
                  dest_q      <= new_port_c;
                  req_q       <= port_onehot(new_port_c);
                  if (ftype_c == FT_HEAD) state_q <= S_PKT;
               end else if (err_q != 8'hFF) begin
                  // Orphan body/tail is dropped
                  err_q <= err_q + 8'd1;
               end
            end else begin
               // Everything inside a packet follows the latched route
               out_flit_q  <= in_flit;
               out_valid_q <= 1'b1;
               dest_q      <= route_q;
               req_q       <= port_onehot(route_q);
               if (ftype_c == FT_TAIL) state_q <= S_IDLE;
               if ((ftype_c == FT_HEAD || ftype_c == FT_SINGLE) && err_q != 8'hFF)
                  err_q <= err_q + 8'd1;
            end
         end
      end
   end

   assign out_flit         = out_flit_q;
   assign out_valid        = out_valid_q;
   assign request_vector   = req_q;
   assign destination_port = dest_q;
   assign err_count        = err_q;

endmodule
